// File: rtl/sram_dump_reader_pkg.sv
// Shared widths and FSM encoding for the SRAM dump reader.
package sram_dump_reader_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned ADDR_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/sram_dump_reader_if.sv
// SRAM read port plus valid/ready output stream of the dump reader.
interface sram_dump_reader_if;

    logic                                       mem_rd_en;
    logic [sram_dump_reader_pkg::ADDR_SIZE-1:0] mem_addr;
    logic [sram_dump_reader_pkg::WORD_SIZE-1:0] mem_rdata;
    logic                                       dout_valid;
    logic                                       dout_ready;
    logic [sram_dump_reader_pkg::WORD_SIZE-1:0] dout_data;
    logic [sram_dump_reader_pkg::ADDR_SIZE-1:0] dout_addr;
    logic                                       dout_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output dout_valid, dout_data, dout_addr, dout_last,
        input  dout_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  dout_valid, dout_data, dout_addr, dout_last,
        output dout_ready
    );

endinterface

// File: rtl/sram_dump_reader.sv
// Reads SRAM range [base_addr..last_addr] (wrapping) and streams it on valid/ready.
// Optional trailing checksum beat enabled by DUMP_CHECKSUM_EN.
module sram_dump_reader
    import sram_dump_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE-1:0] last_addr,
    output logic                 busy,
    output logic                 done,
    sram_dump_reader_if.master   bus
);

    dump_state_e          state_q, state_d;
    logic [ADDR_SIZE-1:0] cur_q, cur_d;
    logic [ADDR_SIZE-1:0] end_q, end_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [WORD_SIZE-1:0] dout_data_q, dout_data_d;
    logic [ADDR_SIZE-1:0] dout_addr_q, dout_addr_d;
    logic                 dout_last_q, dout_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
    logic [WORD_SIZE-1:0] sum_q, sum_d;
    logic                 sum_phase_q, sum_phase_d;
`endif

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_addr_q  <= '0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= '0;
            sum_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_addr_q  <= dout_addr_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
            sum_phase_q  <= sum_phase_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs are loaded one cycle ahead of their state
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        end_d        = end_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_addr_d   = mem_addr_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_addr_d  = dout_addr_q;
        dout_last_d  = dout_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        sum_d        = sum_q;
        sum_phase_d  = sum_phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d       = base_addr;
                    end_d       = last_addr;
                    busy_d      = 1'b1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_addr;
                    state_d     = ST_RD;
`ifdef DUMP_CHECKSUM_EN
                    sum_d       = '0;
                    sum_phase_d = 1'b0;
`endif
                end
            end
            ST_RD: begin
                mem_rd_en_d = 1'b0;
                state_d     = ST_CAP;
            end
            ST_CAP: begin
                dout_data_d  = bus.mem_rdata;
                dout_addr_d  = cur_q;
                dout_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                dout_last_d  = 1'b0;
                sum_d        = sum_q + bus.mem_rdata;
`else
                dout_last_d  = (cur_q == end_q);
`endif
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    if (sum_phase_q) begin
                        sum_phase_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                    end else if (cur_q == end_q) begin
                        // Checksum beat follows the last data word directly
                        dout_valid_d = 1'b1;
                        dout_data_d  = sum_q;
                        dout_addr_d  = '0;
                        dout_last_d  = 1'b1;
                        sum_phase_d  = 1'b1;
                    end else begin
                        cur_d       = cur_q + ADDR_SIZE'(1);
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = cur_q + ADDR_SIZE'(1);
                        state_d     = ST_RD;
                    end
`else
                    if (cur_q == end_q) begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        cur_d       = cur_q + ADDR_SIZE'(1);
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = cur_q + ADDR_SIZE'(1);
                        state_d     = ST_RD;
                    end
`endif
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_addr  = dout_addr_q;
    assign bus.dout_last  = dout_last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
